// File: rtl/truth_table_sweeper.sv
// Sweeps all eight {A,B,C} vectors through a 3-input function, samples F after a
// settle time and assembles the truth table. Optional golden compare: TT_GOLDEN_CHECK_EN.
module truth_table_sweeper #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  EXPECTED = 8'hB2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       in_f,
  output logic       out_a,
  output logic       out_b,
  output logic       out_c,
  output logic       busy,
  output logic       done,
  output logic       table_valid,
  output logic [7:0] table_out
`ifdef TT_GOLDEN_CHECK_EN
  ,
  output logic       pass,
  output logic [7:0] mismatch
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [7:0] table_next;

  // Table as it will look once the current vector's F is captured.
  always_comb begin
    table_next      = table_out;
    table_next[idx] = in_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      out_a       <= 1'b0;
      out_b       <= 1'b0;
      out_c       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_valid <= 1'b0;
      table_out   <= '0;
`ifdef TT_GOLDEN_CHECK_EN
      pass        <= 1'b0;
      mismatch    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort in IDLE leaves everything alone but still blocks a same-cycle start.
        if (state != IDLE) begin
          state                 <= IDLE;
          idx                   <= '0;
          cnt                   <= '0;
          {out_a, out_b, out_c} <= '0;
          busy                  <= 1'b0;
          table_valid           <= 1'b0;
`ifdef TT_GOLDEN_CHECK_EN
          pass                  <= 1'b0;
          mismatch              <= '0;
`endif
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              table_out             <= '0;
              table_valid           <= 1'b0;
              idx                   <= '0;
              cnt                   <= RELOAD;
              {out_a, out_b, out_c} <= '0;
              busy                  <= 1'b1;
              state                 <= DRIVE;
`ifdef TT_GOLDEN_CHECK_EN
              pass                  <= 1'b0;
              mismatch              <= '0;
`endif
            end
          end
          DRIVE: begin
            if (cnt == '0) state <= SAMPLE;
            else           cnt   <= cnt - 4'd1;
          end
          SAMPLE: begin
            table_out <= table_next;
            if (idx == 3'd7) begin
              state                 <= DONE;
              busy                  <= 1'b0;
              done                  <= 1'b1;
              table_valid           <= 1'b1;
              {out_a, out_b, out_c} <= '0;
`ifdef TT_GOLDEN_CHECK_EN
              mismatch              <= table_next ^ EXPECTED;
              pass                  <= (table_next == EXPECTED);
`endif
            end else begin
              idx                   <= idx + 3'd1;
              cnt                   <= RELOAD;
              {out_a, out_b, out_c} <= idx + 3'd1;
              state                 <= DRIVE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
